// File: rtl/seg7_scan_mux_pkg.sv
// Shared constants and the hex-to-segment encoder for the multiplexed 7-segment driver.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {a,b,c,d,e,f,g}; lowercase b and d keep them distinct from 8 and 0.
  function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0001100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Datapath-side value/decimal-point request bus and board-side segment/anode pins.
interface seg7_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    lz_blank_en;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   enable;
  logic                    frame_done;

  modport master (
    output value, dp_in, lz_blank_en,
    input  seg, dp, enable, frame_done
  );

  modport slave (
    input  value, dp_in, lz_blank_en,
    output seg, dp, enable, frame_done
  );
endinterface

// File: rtl/seg7_scan_mux_lz_detect.sv
// Leading-zero mask: digit i is a leading zero when every nibble and dp bit at or above i is 0.
module seg7_lz_detect #(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic [NUM_DIGITS-1:0]   lz_mask
);

  logic zero_run;

  // Digit 0 always shows, so a zero value still displays a single 0.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run && (value[i*4 +: 4] == 4'h0) && !dp[i];
      lz_mask[i] = (i != 0) && zero_run;
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed 7-segment scanner: slot prescaler, digit index, frame snapshot, registered pin drive.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV          = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input logic           internal_clk,
  input logic           rst_n,
  seg7_scan_mux_if.slave bus
);

  localparam int TICK_W = $clog2(DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [TICK_W-1:0] BLANK_END = TICK_W'(BLANK_CYCLES);
  localparam bit BLANK_EN = (BLANK_CYCLES > 0) && (NUM_DIGITS > 1);

  logic [TICK_W-1:0]         tick_q, tick_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   shadow_value_q, shadow_value_d;
  logic [NUM_DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic                      shadow_lz_q, shadow_lz_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic [NUM_DIGITS-1:0]     enable_q, enable_d;
  logic                      frame_done_q, frame_done_d;

  logic [NUM_DIGITS-1:0]     lz_mask;
  logic [3:0]                nibble;
  logic                      digit_dp;
  logic                      digit_lz;
  logic                      tick_last;
  logic                      snap;

  seg7_lz_detect #(.NUM_DIGITS(NUM_DIGITS)) u_lz_detect (
    .value   (shadow_value_q),
    .dp      (shadow_dp_q),
    .lz_mask (lz_mask)
  );

  always_comb begin
    nibble   = 4'h0;
    digit_dp = 1'b0;
    digit_lz = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nibble   = shadow_value_q[i*4 +: 4];
        digit_dp = shadow_dp_q[i];
        digit_lz = lz_mask[i];
      end
    end
  end

  always_comb begin
    tick_last      = (tick_q == TICK_LAST);
    snap           = tick_last && (idx_q == IDX_LAST);
    tick_d         = tick_last ? '0 : tick_q + 1'b1;
    idx_d          = idx_q;
    shadow_value_d = shadow_value_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_lz_d    = shadow_lz_q;

    if (tick_last) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    // Inputs are only sampled at the frame boundary so a frame never mixes two values.
    if (snap) begin
      shadow_value_d = bus.value;
      shadow_dp_d    = bus.dp_in;
      shadow_lz_d    = bus.lz_blank_en;
    end

    frame_done_d = snap;
    if (BLANK_EN && (tick_q < BLANK_END)) begin
      enable_d = {NUM_DIGITS{1'b1}};
    end else begin
      enable_d = ~(NUM_DIGITS'(1) << idx_q);
    end
    if (shadow_lz_q && digit_lz) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end else begin
      seg_d = hex_to_seg7(nibble);
      dp_d  = ~digit_dp;
    end
  end

  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q         <= '0;
      idx_q          <= '0;
      shadow_value_q <= '0;
      shadow_dp_q    <= '0;
      shadow_lz_q    <= 1'b0;
      seg_q          <= SEG_BLANK;
      dp_q           <= 1'b1;
      enable_q       <= {NUM_DIGITS{1'b1}};
      frame_done_q   <= 1'b0;
    end else begin
      tick_q         <= tick_d;
      idx_q          <= idx_d;
      shadow_value_q <= shadow_value_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_lz_q    <= shadow_lz_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      enable_q       <= enable_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.enable     = enable_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux at NUM_DIGITS=4, DIV=8, BLANK_CYCLES=2.
module tb_seg7_scan_mux;

  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = ND * DIV;

  typedef struct packed {
    logic [3:0] en;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   s        = 0;
  logic [15:0] sh_val = '0;
  logic [3:0]  sh_dp  = '0;
  logic        sh_lz  = 1'b0;
  obs_t sb[$];
  logic [6:0] enc [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  always #5 clk = ~clk;

  seg7_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_mux #(.NUM_DIGITS(ND), .DIV(DIV), .BLANK_CYCLES(BLK)) dut (
    .internal_clk (clk),
    .rst_n        (rst_n),
    .bus          (bus)
  );

  function automatic obs_t observed();
    return {bus.enable, bus.seg, bus.dp, bus.frame_done};
  endfunction

  // Predict the pins for the current (tick, idx), then advance one clock.
  task automatic step();
    obs_t e;
    int t, ix;
    logic lzd;
    logic [3:0] nib;
    t   = s % DIV;
    ix  = (s / DIV) % ND;
    nib = sh_val[ix*4 +: 4];
    lzd = sh_lz && (ix != 0) && ((sh_val >> (4*ix)) == 16'h0) && ((sh_dp >> ix) == 4'h0);
    e.en  = (t < BLK) ? 4'hF : ~(4'b0001 << ix);
    e.seg = lzd ? 7'h7F : enc[nib];
    e.dp  = lzd ? 1'b1 : ~sh_dp[ix];
    e.fd  = ((s % FRAME) == FRAME - 1);
    if (e.fd) begin
      sh_val = bus.value;
      sh_dp  = bus.dp_in;
      sh_lz  = bus.lz_blank_en;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    s++;
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    s      = 0;
    sh_val = '0;
    sh_dp  = '0;
    sh_lz  = 1'b0;
    sb.delete();
  endtask

  task automatic set_inputs(input logic [15:0] v, input logic [3:0] d, input logic lz);
    bus.value       = v;
    bus.dp_in       = d;
    bus.lz_blank_en = lz;
  endtask

  task automatic test_reset();
    obs_t e, got;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (observed() !== obs_t'({4'hF, 7'h7F, 1'b1, 1'b0}))
      $display("FAIL reset_initial got=%h exp=%h", observed(), obs_t'({4'hF, 7'h7F, 1'b1, 1'b0}));
    else n_pass++;
    release_reset();
    n_checks++;
    if (observed() !== obs_t'({4'hF, 7'h7F, 1'b1, 1'b0}))
      $display("FAIL reset_release got=%h", observed());
    else n_pass++;
    for (int c = 0; c < 13; c++) begin
      step();
      e = sb.pop_front();
      got = observed();
      n_checks++;
      if (got !== e) $display("FAIL reset_run state=%0d got=%h exp=%h", s - 1, got, e);
      else n_pass++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (observed() !== obs_t'({4'hF, 7'h7F, 1'b1, 1'b0}))
      $display("FAIL reset_async got=%h", observed());
    else n_pass++;
    release_reset();
  endtask

  task automatic test_hex_digits();
    obs_t e, got;
    int cnt [4];
    logic [15:0] pats [5];
    logic [3:0]  en_exp [4];
    logic [6:0]  seg_exp [4];
    pats    = '{16'h12AF, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    en_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_exp = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
    for (int p = 0; p < 5; p++) begin
      set_inputs(pats[p], 4'h0, 1'b0);
      cnt = '{0, 0, 0, 0};
      do begin
        step();
        e = sb.pop_front();
        got = observed();
        n_checks++;
        if (got !== e) $display("FAIL hex_align pat=%h state=%0d got=%h exp=%h", pats[p], s - 1, got, e);
        else n_pass++;
      end while (s % FRAME != 0);
      for (int c = 0; c < FRAME; c++) begin
        step();
        e = sb.pop_front();
        got = observed();
        n_checks++;
        if (got !== e) $display("FAIL hex_frame pat=%h state=%0d got=%h exp=%h", pats[p], s - 1, got, e);
        else n_pass++;
        for (int d = 0; d < 4; d++)
          if (bus.enable == en_exp[d] && bus.seg == seg_exp[d]) cnt[d]++;
      end
      if (p == 0) begin
        for (int d = 0; d < 4; d++) begin
          n_checks++;
          if (cnt[d] != 6) $display("FAIL hex_12AF_digit%0d lit_cycles got=%0d exp=6", d, cnt[d]);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_lz_blank();
    obs_t e, got;
    int blanks;
    logic [15:0] vals [2];
    int exp_blank [2];
    vals      = '{16'h0050, 16'h0000};
    exp_blank = '{16, 24};
    for (int p = 0; p < 2; p++) begin
      set_inputs(vals[p], 4'h0, 1'b1);
      blanks = 0;
      do begin
        step();
        e = sb.pop_front();
        got = observed();
        n_checks++;
        if (got !== e) $display("FAIL lz_align val=%h state=%0d got=%h exp=%h", vals[p], s - 1, got, e);
        else n_pass++;
      end while (s % FRAME != 0);
      for (int c = 0; c < FRAME; c++) begin
        step();
        e = sb.pop_front();
        got = observed();
        n_checks++;
        if (got !== e) $display("FAIL lz_frame val=%h state=%0d got=%h exp=%h", vals[p], s - 1, got, e);
        else n_pass++;
        if (bus.seg == 7'h7F) blanks++;
      end
      n_checks++;
      if (blanks != exp_blank[p]) $display("FAIL lz_blank_cycles val=%h got=%0d exp=%0d", vals[p], blanks, exp_blank[p]);
      else n_pass++;
    end
  endtask

  task automatic test_dp_lz();
    obs_t e, got;
    int dp_lit, blanks;
    set_inputs(16'h0012, 4'b0100, 1'b1);
    dp_lit = 0;
    blanks = 0;
    do begin
      step();
      e = sb.pop_front();
      got = observed();
      n_checks++;
      if (got !== e) $display("FAIL dp_align state=%0d got=%h exp=%h", s - 1, got, e);
      else n_pass++;
    end while (s % FRAME != 0);
    for (int c = 0; c < FRAME; c++) begin
      step();
      e = sb.pop_front();
      got = observed();
      n_checks++;
      if (got !== e) $display("FAIL dp_frame state=%0d got=%h exp=%h", s - 1, got, e);
      else n_pass++;
      if (bus.dp == 1'b0) dp_lit++;
      if (bus.seg == 7'h7F) blanks++;
    end
    n_checks++;
    if (dp_lit != 8 || blanks != 8) $display("FAIL dp_counts dp_lit=%0d blank=%0d exp=8,8", dp_lit, blanks);
    else n_pass++;
  endtask

  task automatic test_snapshot();
    obs_t e, got;
    set_inputs(16'h1234, 4'h0, 1'b0);
    do begin
      step();
      e = sb.pop_front();
      got = observed();
      n_checks++;
      if (got !== e) $display("FAIL snap_align state=%0d got=%h exp=%h", s - 1, got, e);
      else n_pass++;
    end while (s % FRAME != 0);
    for (int c = 0; c < 3 * FRAME; c++) begin
      if (c == FRAME + 10) set_inputs(16'hABCD, 4'h0, 1'b0);
      step();
      e = sb.pop_front();
      got = observed();
      n_checks++;
      if (got !== e) $display("FAIL snap_frame state=%0d got=%h exp=%h", s - 1, got, e);
      else n_pass++;
      if (c == FRAME + 28) begin
        n_checks++;
        if (bus.enable !== 4'b0111 || bus.seg !== 7'b1001111)
          $display("FAIL snap_hold en=%b seg=%b exp=0111,1001111", bus.enable, bus.seg);
        else n_pass++;
      end
      if (c == 2 * FRAME + 28) begin
        n_checks++;
        if (bus.enable !== 4'b0111 || bus.seg !== 7'b0001000)
          $display("FAIL snap_next en=%b seg=%b exp=0111,0001000", bus.enable, bus.seg);
        else n_pass++;
      end
    end
  endtask

  task automatic test_frame_done();
    obs_t e, got;
    int first, gap, since;
    first = -1;
    gap   = -1;
    for (int c = 0; c < 70; c++) begin
      step();
      e = sb.pop_front();
      got = observed();
      n_checks++;
      if (got !== e) $display("FAIL fd_run state=%0d got=%h exp=%h", s - 1, got, e);
      else n_pass++;
      if (bus.frame_done) begin
        if (first < 0) first = c;
        else if (gap < 0) gap = c - first;
      end
    end
    n_checks++;
    if (gap != FRAME) $display("FAIL fd_period got=%0d exp=%0d", gap, FRAME);
    else n_pass++;
    repeat (10) begin
      step();
      void'(sb.pop_front());
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (observed() !== obs_t'({4'hF, 7'h7F, 1'b1, 1'b0}))
      $display("FAIL fd_reset_async got=%h", observed());
    else n_pass++;
    release_reset();
    since = -1;
    for (int c = 1; c <= 100 && since < 0; c++) begin
      step();
      e = sb.pop_front();
      got = observed();
      n_checks++;
      if (got !== e) $display("FAIL fd_after_reset state=%0d got=%h exp=%h", s - 1, got, e);
      else n_pass++;
      if (bus.frame_done) since = c;
    end
    n_checks++;
    if (since != FRAME) $display("FAIL fd_first_after_reset got=%0d exp=%0d", since, FRAME);
    else n_pass++;
  endtask

  initial begin
    set_inputs(16'h0000, 4'h0, 1'b0);
    test_reset();
    test_hex_digits();
    test_lz_blank();
    test_dp_lz();
    test_snapshot();
    test_frame_done();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench watchdog");
  end

endmodule
